// File: rtl/datamem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory unit.
//   Port A : single-beat CPU load/store requester (a_*)
//   Port B : incrementing word-burst DMA/loader requester (b_*)
//   Memory : shared access port of the data memory unit (mem_*)
// modport slave  : arbiter view (requests/read data in, grants/memory drive out)
// modport master : requester + memory view (the opposite directions)
interface datamem_arbiter_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned BURST_WIDTH   = 4
);
    // Port A
    logic                     a_req;
    logic [ADDRESS_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0]    a_wdata;
    logic [2:0]               a_ctrl;
    logic                     a_we;
    logic                     a_gnt;
    logic [DATA_WIDTH-1:0]    a_rdata;
    logic                     a_rvalid;
    // Port B
    logic                     b_req;
    logic [ADDRESS_WIDTH-1:0] b_addr;
    logic [BURST_WIDTH-1:0]   b_len;
    logic [DATA_WIDTH-1:0]    b_wdata;
    logic [2:0]               b_ctrl;
    logic                     b_we;
    logic                     b_gnt;
    logic [DATA_WIDTH-1:0]    b_rdata;
    logic                     b_rvalid;
    logic                     b_done;
    // Memory unit
    logic [ADDRESS_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0]    mem_write_data;
    logic [2:0]               mem_ctrl;
    logic                     mem_write_enable;
    logic [DATA_WIDTH-1:0]    mem_read_data;

    modport slave (
        input  a_req, a_addr, a_wdata, a_ctrl, a_we,
        output a_gnt, a_rdata, a_rvalid,
        input  b_req, b_addr, b_len, b_wdata, b_ctrl, b_we,
        output b_gnt, b_rdata, b_rvalid, b_done,
        output mem_address, mem_write_data, mem_ctrl, mem_write_enable,
        input  mem_read_data
    );

    modport master (
        output a_req, a_addr, a_wdata, a_ctrl, a_we,
        input  a_gnt, a_rdata, a_rvalid,
        output b_req, b_addr, b_len, b_wdata, b_ctrl, b_we,
        input  b_gnt, b_rdata, b_rvalid, b_done,
        input  mem_address, mem_write_data, mem_ctrl, mem_write_enable,
        output mem_read_data
    );
endinterface

// File: rtl/datamem_arbiter.sv
// Two-port arbiter and burst sequencer in front of the data memory unit.
// Port A issues single accesses, port B issues incrementing word bursts; on
// contention in IDLE the port that did not own the memory last wins.
// Grants and memory drive are combinational; read data, rvalid and b_done are
// registered one cycle after the access.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : datamem_arbiter_if.slave (port A, port B, memory unit signals)
module datamem_arbiter #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned BURST_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    datamem_arbiter_if.slave      bus
);
    localparam logic [ADDRESS_WIDTH-1:0] WORD_STEP = ADDRESS_WIDTH'(4);
    localparam logic [BURST_WIDTH-1:0]   CNT_ONE   = BURST_WIDTH'(1);

    typedef enum logic { ST_IDLE, ST_BURST } state_t;
    typedef enum logic { OWN_A, OWN_B } owner_t;

    state_t                   r_state;
    owner_t                   r_last_owner;
    logic [BURST_WIDTH-1:0]   r_cnt;
    logic [BURST_WIDTH-1:0]   r_len;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic                     r_we;
    logic [2:0]               r_ctrl;
    logic [DATA_WIDTH-1:0]    r_a_rdata;
    logic                     r_a_rvalid;
    logic [DATA_WIDTH-1:0]    r_b_rdata;
    logic                     r_b_rvalid;
    logic                     r_b_done;

    logic                     w_a_gnt;
    logic                     w_b_first;
    logic                     w_b_beat;
    logic                     w_b_gnt;
    logic                     w_b_we;
    logic                     w_b_last;

    // Grant decision; gated by rst_n so nothing reaches memory while in reset.
    always_comb begin
        w_a_gnt   = 1'b0;
        w_b_first = 1'b0;
        w_b_beat  = 1'b0;
        if (rst_n) begin
            if (r_state == ST_IDLE) begin
                if (bus.a_req && (!bus.b_req || r_last_owner == OWN_B)) begin
                    w_a_gnt = 1'b1;
                end else if (bus.b_req) begin
                    w_b_first = 1'b1;
                end
            end else begin
                w_b_beat = bus.b_req;
            end
        end
    end

    assign w_b_gnt  = w_b_first | w_b_beat;
    assign w_b_we   = w_b_first ? bus.b_we : r_we;
    assign w_b_last = w_b_first ? (bus.b_len == '0) : (r_cnt == r_len);

    // Memory mux: beat 0 uses the live port-B fields, later beats the latched ones.
    always_comb begin
        bus.mem_address      = '0;
        bus.mem_write_data   = '0;
        bus.mem_ctrl         = '0;
        bus.mem_write_enable = 1'b0;
        if (w_a_gnt) begin
            bus.mem_address      = bus.a_addr;
            bus.mem_write_data   = bus.a_wdata;
            bus.mem_ctrl         = bus.a_ctrl;
            bus.mem_write_enable = bus.a_we;
        end else if (w_b_first) begin
            bus.mem_address      = bus.b_addr;
            bus.mem_write_data   = bus.b_wdata;
            bus.mem_ctrl         = bus.b_ctrl;
            bus.mem_write_enable = bus.b_we;
        end else if (w_b_beat) begin
            bus.mem_address      = r_addr;
            bus.mem_write_data   = bus.b_wdata;
            bus.mem_ctrl         = r_ctrl;
            bus.mem_write_enable = r_we;
        end
    end

    // State, burst bookkeeping and registered read return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_owner <= OWN_B;
            r_cnt        <= '0;
            r_len        <= '0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_ctrl       <= '0;
            r_a_rdata    <= '0;
            r_a_rvalid   <= 1'b0;
            r_b_rdata    <= '0;
            r_b_rvalid   <= 1'b0;
            r_b_done     <= 1'b0;
        end else begin
            r_a_rvalid <= w_a_gnt && !bus.a_we;
            if (w_a_gnt && !bus.a_we) begin
                r_a_rdata <= bus.mem_read_data;
            end
            r_b_rvalid <= w_b_gnt && !w_b_we;
            if (w_b_gnt && !w_b_we) begin
                r_b_rdata <= bus.mem_read_data;
            end
            // An aborted burst never reaches its last beat, so no done pulse.
            r_b_done <= w_b_gnt && w_b_last;

            case (r_state)
                ST_IDLE: begin
                    if (w_a_gnt) begin
                        r_last_owner <= OWN_A;
                    end else if (w_b_first) begin
                        if (w_b_last) begin
                            r_last_owner <= OWN_B;
                        end else begin
                            r_state <= ST_BURST;
                            r_cnt   <= CNT_ONE;
                            r_addr  <= bus.b_addr + WORD_STEP;
                            r_len   <= bus.b_len;
                            r_we    <= bus.b_we;
                            r_ctrl  <= bus.b_ctrl;
                        end
                    end
                end
                ST_BURST: begin
                    if (w_b_beat) begin
                        r_addr <= r_addr + WORD_STEP;
                        r_cnt  <= r_cnt + CNT_ONE;
                        if (w_b_last) begin
                            r_state      <= ST_IDLE;
                            r_last_owner <= OWN_B;
                        end
                    end else begin
                        r_state      <= ST_IDLE;
                        r_last_owner <= OWN_B;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.a_gnt    = w_a_gnt;
    assign bus.a_rdata  = r_a_rdata;
    assign bus.a_rvalid = r_a_rvalid;
    assign bus.b_gnt    = w_b_gnt;
    assign bus.b_rdata  = r_b_rdata;
    assign bus.b_rvalid = r_b_rvalid;
    assign bus.b_done   = r_b_done;
endmodule

// File: tb/tb_datamem_arbiter.sv
// Bench for datamem_arbiter: behavioural memory unit, expected read data
// queued per port when a read is issued and popped when rvalid appears.
module tb_datamem_arbiter;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned BW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    datamem_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BURST_WIDTH(BW)) bus();

    datamem_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BURST_WIDTH(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory unit: synchronous write, combinational read, 256 words.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (bus.mem_write_enable) mem[bus.mem_address[9:2]] <= bus.mem_write_data;
    end
    assign bus.mem_read_data = mem[bus.mem_address[9:2]];

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t a_q[$];
    exp_t b_q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [31:0] d);
        exp_t x;
        x.data = d;
        x.cyc  = cyc + 1;
        a_q.push_back(x);
    endtask

    task automatic push_b(input logic [31:0] d);
        exp_t x;
        x.data = d;
        x.cyc  = cyc + 1;
        b_q.push_back(x);
    endtask

    // Read-return scoreboard: data and arrival cycle must match.
    always @(negedge clk) begin
        if (bus.a_rvalid) begin
            if (a_q.size() == 0) begin
                check_eq("a_rvalid_spurious", 32'(bus.a_rvalid), 32'd0);
            end else begin
                e = a_q.pop_front();
                check_eq("a_rdata", bus.a_rdata, e.data);
                check_eq("a_rvalid_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (a_q.size() != 0 && a_q[0].cyc <= cyc) begin
            check_eq("a_rvalid_missing", 32'(bus.a_rvalid), 32'd1);
            void'(a_q.pop_front());
        end
        if (bus.b_rvalid) begin
            if (b_q.size() == 0) begin
                check_eq("b_rvalid_spurious", 32'(bus.b_rvalid), 32'd0);
            end else begin
                e = b_q.pop_front();
                check_eq("b_rdata", bus.b_rdata, e.data);
                check_eq("b_rvalid_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (b_q.size() != 0 && b_q[0].cyc <= cyc) begin
            check_eq("b_rvalid_missing", 32'(bus.b_rvalid), 32'd1);
            void'(b_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        bus.a_req = 0; bus.a_addr = '0; bus.a_wdata = '0; bus.a_ctrl = '0; bus.a_we = 0;
        bus.b_req = 0; bus.b_addr = '0; bus.b_len = '0; bus.b_wdata = '0; bus.b_ctrl = '0; bus.b_we = 0;

        // Reset values
        @(negedge clk);
        check_eq("rst_a_rvalid", 32'(bus.a_rvalid), 32'd0);
        check_eq("rst_b_rvalid", 32'(bus.b_rvalid), 32'd0);
        check_eq("rst_b_done", 32'(bus.b_done), 32'd0);
        check_eq("rst_a_rdata", bus.a_rdata, 32'd0);
        check_eq("rst_b_rdata", bus.b_rdata, 32'd0);
        check_eq("rst_mem_we", 32'(bus.mem_write_enable), 32'd0);
        tick();
        rst_n = 1;
        tick();

        // A write then A read of 0x10
        bus.a_req = 1; bus.a_addr = 32'h10; bus.a_wdata = 32'hDEADBEEF; bus.a_ctrl = 3'b010; bus.a_we = 1;
        @(negedge clk);
        check_eq("aw_gnt", 32'(bus.a_gnt), 32'd1);
        check_eq("aw_mem_we", 32'(bus.mem_write_enable), 32'd1);
        check_eq("aw_mem_addr", bus.mem_address, 32'h10);
        check_eq("aw_mem_wdata", bus.mem_write_data, 32'hDEADBEEF);
        check_eq("aw_mem_ctrl", 32'(bus.mem_ctrl), 32'd2);
        tick();
        bus.a_we = 0;
        @(negedge clk);
        check_eq("ar_gnt", 32'(bus.a_gnt), 32'd1);
        check_eq("ar_mem_we", 32'(bus.mem_write_enable), 32'd0);
        check_eq("aw_no_rvalid", 32'(bus.a_rvalid), 32'd0);
        push_a(32'hDEADBEEF);
        tick();
        bus.a_req = 0;
        tick();

        // Contention after reset: A first, then alternate
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 32'h20; bus.a_wdata = 32'h11;
        bus.b_req = 1; bus.b_we = 1; bus.b_addr = 32'h40; bus.b_wdata = 32'h22; bus.b_len = '0; bus.b_ctrl = 3'b010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq($sformatf("cont_a_gnt%0d", i), 32'(bus.a_gnt), 32'((i % 2) == 0));
            check_eq($sformatf("cont_b_gnt%0d", i), 32'(bus.b_gnt), 32'((i % 2) == 1));
            check_eq($sformatf("cont_b_done%0d", i), 32'(bus.b_done), 32'(i > 0 && (i % 2) == 0));
            tick();
        end
        bus.a_req = 0; bus.b_req = 0;
        tick();

        // B write burst len=3 from 0x100 with A read of 0x10 waiting (A owned last)
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 32'h10;
        bus.b_req = 1; bus.b_addr = 32'h100; bus.b_len = 4'd3; bus.b_we = 1;
        for (int k = 0; k < 4; k++) begin
            bus.b_wdata = 32'(k + 1);
            @(negedge clk);
            check_eq($sformatf("bw_b_gnt%0d", k), 32'(bus.b_gnt), 32'd1);
            check_eq($sformatf("bw_a_gnt%0d", k), 32'(bus.a_gnt), 32'd0);
            check_eq($sformatf("bw_addr%0d", k), bus.mem_address, 32'h100 + 32'(4 * k));
            check_eq($sformatf("bw_wdata%0d", k), bus.mem_write_data, 32'(k + 1));
            check_eq($sformatf("bw_we%0d", k), 32'(bus.mem_write_enable), 32'd1);
            check_eq($sformatf("bw_done%0d", k), 32'(bus.b_done), 32'd0);
            tick();
        end
        bus.b_req = 0;
        @(negedge clk);
        check_eq("bw_done_end", 32'(bus.b_done), 32'd1);
        check_eq("bw_a_after", 32'(bus.a_gnt), 32'd1);
        check_eq("bw_a_addr", bus.mem_address, 32'h10);
        push_a(32'hDEADBEEF);
        tick();
        bus.a_req = 0;
        tick();

        // B read burst len=1 from 0x100
        bus.b_req = 1; bus.b_addr = 32'h100; bus.b_len = 4'd1; bus.b_we = 0;
        @(negedge clk);
        check_eq("br_gnt0", 32'(bus.b_gnt), 32'd1);
        check_eq("br_addr0", bus.mem_address, 32'h100);
        check_eq("br_we0", 32'(bus.mem_write_enable), 32'd0);
        push_b(32'd1);
        tick();
        @(negedge clk);
        check_eq("br_gnt1", 32'(bus.b_gnt), 32'd1);
        check_eq("br_addr1", bus.mem_address, 32'h104);
        check_eq("br_done1", 32'(bus.b_done), 32'd0);
        push_b(32'd2);
        tick();
        bus.b_req = 0;
        @(negedge clk);
        check_eq("br_done2", 32'(bus.b_done), 32'd1);
        check_eq("br_rvalid2", 32'(bus.b_rvalid), 32'd1);
        tick();

        // Abort at beat 2 of a len=3 write burst from 0x200
        bus.b_req = 1; bus.b_addr = 32'h200; bus.b_len = 4'd3; bus.b_we = 1;
        for (int k = 0; k < 2; k++) begin
            bus.b_wdata = 32'hA0 + 32'(k);
            @(negedge clk);
            check_eq($sformatf("ab_gnt%0d", k), 32'(bus.b_gnt), 32'd1);
            tick();
        end
        bus.b_req = 0; bus.b_wdata = 32'hA2;
        @(negedge clk);
        check_eq("ab_gnt2", 32'(bus.b_gnt), 32'd0);
        check_eq("ab_we2", 32'(bus.mem_write_enable), 32'd0);
        check_eq("ab_addr2", bus.mem_address, 32'd0);
        check_eq("ab_wdata2", bus.mem_write_data, 32'd0);
        check_eq("ab_done2", 32'(bus.b_done), 32'd0);
        tick();
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 32'h208;
        @(negedge clk);
        check_eq("ab_idle_a_gnt", 32'(bus.a_gnt), 32'd1);
        check_eq("ab_done3", 32'(bus.b_done), 32'd0);
        push_a(32'd0);
        tick();
        bus.a_req = 0;
        tick();

        // Address wrap: len=1 from 0xFFFFFFFC
        bus.b_req = 1; bus.b_addr = 32'hFFFFFFFC; bus.b_len = 4'd1; bus.b_we = 1; bus.b_wdata = 32'h55;
        @(negedge clk);
        check_eq("wr_addr0", bus.mem_address, 32'hFFFFFFFC);
        tick();
        bus.b_wdata = 32'h66;
        @(negedge clk);
        check_eq("wr_addr1", bus.mem_address, 32'h0);
        check_eq("wr_gnt1", 32'(bus.b_gnt), 32'd1);
        tick();
        bus.b_req = 0;
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 32'h0;
        @(negedge clk);
        check_eq("wr_done", 32'(bus.b_done), 32'd1);
        check_eq("wr_a_gnt", 32'(bus.a_gnt), 32'd1);
        push_a(32'h66);
        tick();
        bus.a_req = 0;
        tick();

        // Reset during a len=7 write burst from 0x300
        bus.b_req = 1; bus.b_addr = 32'h300; bus.b_len = 4'd7; bus.b_we = 1; bus.b_wdata = 32'h77;
        tick();
        tick();
        rst_n = 0;
        #1;
        check_eq("rb_mem_we", 32'(bus.mem_write_enable), 32'd0);
        check_eq("rb_b_gnt", 32'(bus.b_gnt), 32'd0);
        check_eq("rb_mem_addr", bus.mem_address, 32'd0);
        check_eq("rb_b_done", 32'(bus.b_done), 32'd0);
        check_eq("rb_b_rvalid", 32'(bus.b_rvalid), 32'd0);
        check_eq("rb_b_rdata", bus.b_rdata, 32'd0);
        check_eq("rb_a_rdata", bus.a_rdata, 32'd0);
        @(negedge clk);
        check_eq("rb_mem_we_hold", 32'(bus.mem_write_enable), 32'd0);
        bus.b_req = 0;
        tick();
        rst_n = 1;
        tick();
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 32'h308;
        @(negedge clk);
        check_eq("rb_idle_a_gnt", 32'(bus.a_gnt), 32'd1);
        check_eq("rb_done_after", 32'(bus.b_done), 32'd0);
        push_a(32'd0);
        tick();
        bus.a_req = 0;
        tick();
        tick();

        check_eq("a_q_drained", 32'(a_q.size()), 32'd0);
        check_eq("b_q_drained", 32'(b_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
